// File: rtl/formula_pkg.sv
// Shared widths and types for the three-root formula pipeline and its collector.
package formula_pkg;
    localparam int RES_W              = 32;
    localparam int FORMULA_FIFO_DEPTH = 8;

    typedef logic [RES_W-1:0] res_t;
endpackage

// File: rtl/formula_fifo_mem.sv
// DEPTH x WIDTH register array; one write port, registered read with write bypass.
// rdata reflects mem[raddr] after this cycle's write, so a word written now is readable next cycle.
module formula_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
        rdata_d = mem_d[raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/formula_res_collector.sv
// Buffers formula pipe results in a FIFO with valid/ready output and issues upstream credits.
// Results are visible one cycle after res_vld; a push on a full FIFO without a pop is dropped and sets overflow.
module formula_res_collector
    import formula_pkg::*;
#(
    parameter int WIDTH = RES_W,
    parameter int DEPTH = FORMULA_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_vld,
    output logic                     issue_rdy,
    input  logic                     res_vld,
    input  logic [WIDTH-1:0]         res,
    output logic                     out_vld,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_rdy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] reserved_q, reserved_d;
    logic          overflow_q, overflow_d;
    logic          full, pop, push, issue;

    always_comb begin
        full       = (level_q == LW'(DEPTH));
        pop        = (level_q != '0) && out_rdy;
        push       = res_vld && (!full || pop);
        issue      = issue_vld && (reserved_q < LW'(DEPTH));
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        overflow_d = overflow_q || (res_vld && full && !pop);

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end

        // Saturate at zero: orphan results from before a reset pop without a matching credit.
        reserved_d = reserved_q;
        if (issue && !pop) begin
            reserved_d = reserved_q + LW'(1);
        end else if (pop && !issue && reserved_q != '0) begin
            reserved_d = reserved_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            reserved_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            reserved_q <= reserved_d;
            overflow_q <= overflow_d;
        end
    end

    formula_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (res),
        .raddr (rd_ptr_d),
        .rdata (out_data)
    );

    assign issue_rdy = (reserved_q < LW'(DEPTH));
    assign out_vld   = (level_q != '0);
    assign level     = level_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_formula_res_collector.sv
// Randomized scoreboard bench for formula_res_collector with a queue-based reference model.
module tb_formula_res_collector;
    import formula_pkg::*;

    localparam int D   = FORMULA_FIFO_DEPTH;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_vld;
    logic        issue_rdy;
    logic        res_vld;
    res_t        res;
    logic        out_vld;
    res_t        out_data;
    logic        out_rdy;
    logic [$clog2(D):0] level;
    logic        overflow;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    int   m_level = 0;
    int   m_res   = 0;
    bit   m_ovf   = 0;
    bit   pv[LAT];
    res_t pd[LAT];

    formula_res_collector dut (
        .clk       (clk),
        .rst       (rst),
        .issue_vld (issue_vld),
        .issue_rdy (issue_rdy),
        .res_vld   (res_vld),
        .res       (res),
        .out_vld   (out_vld),
        .out_data  (out_data),
        .out_rdy   (out_rdy),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic int unsigned isqrt(input int unsigned x);
        int unsigned r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic res_t formula(input int unsigned a, input int unsigned b, input int unsigned c);
        return res_t'(isqrt(a) + isqrt(b) + isqrt(c));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every accepted head is compared with the oldest expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && out_vld === 1'b1 && out_rdy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_data: got %0h expected nothing (scoreboard empty)", out_data);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                end
            end
        end
    end

    // One clock: drive inputs, check registered outputs against the model, then advance the model.
    task automatic step(input logic iv, input logic rv, input res_t rd, input logic ordy, input logic r);
        bit pop, full, acc, iss;
        issue_vld = iv;
        res_vld   = rv;
        res       = rd;
        out_rdy   = ordy;
        rst       = r;
        @(negedge clk);
        chk("level", 32'(level), 32'(m_level));
        chk("out_vld", 32'(out_vld), 32'(m_level > 0));
        chk("issue_rdy", 32'(issue_rdy), 32'(m_res < D));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (r) begin
            m_level = 0;
            m_res   = 0;
            m_ovf   = 0;
            exp_q.delete();
        end else begin
            pop  = (m_level > 0) && ordy;
            full = (m_level == D);
            acc  = rv && (!full || pop);
            iss  = iv && (m_res < D);
            if (rv && !acc) m_ovf = 1;
            if (acc) exp_q.push_back(rd);
            m_level = m_level + int'(acc) - int'(pop);
            if (iss && !pop) m_res++;
            else if (pop && !iss && m_res > 0) m_res--;
        end
        @(posedge clk);
        #1;
    endtask

    // Upstream launch through a fixed-latency model of the formula pipe.
    task automatic pstep(input logic iv, input res_t val, input logic ordy, input logic r);
        logic rv;
        res_t rd;
        rv = pv[LAT-1];
        rd = pd[LAT-1];
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = iv;
        pd[0] = val;
        step(iv, rv, rd, ordy, r);
    endtask

    task automatic flush_pipe(input logic ordy);
        for (int i = 0; i < LAT; i++) pstep(1'b0, '0, ordy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && m_level > 0; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("drain_level", 32'(level), 32'd0);
    endtask

    task automatic fill(input int base);
        for (int i = 0; i < D; i++) step(1'b0, 1'b1, res_t'(base + i), 1'b0, 1'b0);
    endtask

    task automatic rand_issue(input logic ordy);
        res_t v;
        v = formula($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535));
        pstep(m_res < D, v, ordy, 1'b0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < LAT; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        rst = 1'b1; issue_vld = 1'b0; res_vld = 1'b0; res = '0; out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_issue_rdy", 32'(issue_rdy), 32'd1);
        @(posedge clk);
        #1;

        // Single result: 2+3+4
        pstep(1'b1, formula(4, 9, 16), 1'b1, 1'b0);
        chk("t1_expected_value", 32'(exp_q.size() == 0 ? formula(4, 9, 16) : 0), 32'd9);
        flush_pipe(1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Credit exhaustion, a rejected protocol-violating issue, then one pop returns a credit
        for (int i = 0; i < D; i++) rand_issue(1'b0);
        flush_pipe(1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        drain();

        // Ordering and pointer wrap with a toggling consumer
        n = 0;
        for (int c = 0; c < 200 && n < 20; c++) begin
            logic rv;
            rv = (m_level < D - 1);
            step(1'b0, rv, res_t'(n + 1), (c % 2) == 0, 1'b0);
            if (rv) n++;
        end
        drain();

        // Full with simultaneous push and pop
        fill(32'h100);
        step(1'b0, 1'b1, 32'hDEAD, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        drain();

        // Overflow is sticky until reset
        fill(32'h200);
        step(1'b0, 1'b1, 32'hBEEF, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Reset while three triples are in flight; orphans must not wrap the credit counter
        for (int i = 0; i < 3; i++) rand_issue(1'b0);
        pstep(1'b0, '0, 1'b0, 1'b1);
        flush_pipe(1'b0);
        drain();
        for (int i = 0; i < D; i++) rand_issue(1'b0);
        flush_pipe(1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            res_t v;
            v = formula($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535));
            pstep(($urandom_range(0, 2) != 0) && (m_res < D), v, $urandom_range(0, 1) == 1, 1'b0);
        end
        flush_pipe(1'b1);
        drain();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
